// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the two-port memory bus arbiter.
// Field widths here bound the ADDR_W/DATA_W that the arbiter supports.
package mem_bus_arbiter_pkg;

  localparam int MEMREQ_ADDR_W = 32;
  localparam int MEMREQ_DATA_W = 32;
  localparam int MEMREQ_STRB_W = MEMREQ_DATA_W / 8;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                     mode;
    logic [MEMREQ_ADDR_W-1:0] addr;
    logic [MEMREQ_DATA_W-1:0] wdata;
    logic [MEMREQ_STRB_W-1:0] wstrb;
  } memreq_t;

  // Round-robin pick: a lone pending port wins, a tie goes to the port not granted last.
  function automatic logic pick_port(input logic pend0, input logic pend1, input logic last_grant);
    if (pend0 && pend1) begin
      return ~last_grant;
    end
    return pend1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_req_slot.sv
// One requester slot: latches a request pulse and holds it pending until the
// arbiter clears it on the routed response.
module mem_bus_arbiter_req_slot
  import mem_bus_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rstn,
  input  logic    request_enable,
  input  memreq_t req,
  input  logic    clear,
  output logic    pend,
  output memreq_t slot
);

  logic    pend_reg;
  memreq_t slot_reg;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pend_reg <= 1'b0;
      slot_reg <= '0;
    end else if (clear) begin
      pend_reg <= 1'b0;
    end else if (request_enable && !pend_reg) begin
      // A pulse while already pending is a protocol violation and is dropped.
      pend_reg <= 1'b1;
      slot_reg <= req;
    end
  end

  assign pend = pend_reg;
  assign slot = slot_reg;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter for the core memory bus: fetch on port 0,
// mem stage on port 1, one outstanding bus transaction at a time.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = MEMREQ_ADDR_W,
  parameter int DATA_W = MEMREQ_DATA_W
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                s0_request_enable,
  input  logic                s0_mode,
  input  logic [ADDR_W-1:0]   s0_addr,
  input  logic [DATA_W-1:0]   s0_wdata,
  input  logic [DATA_W/8-1:0] s0_wstrb,
  output logic                s0_response_enable,
  output logic [DATA_W-1:0]   s0_data,
  input  logic                s1_request_enable,
  input  logic                s1_mode,
  input  logic [ADDR_W-1:0]   s1_addr,
  input  logic [DATA_W-1:0]   s1_wdata,
  input  logic [DATA_W/8-1:0] s1_wstrb,
  output logic                s1_response_enable,
  output logic [DATA_W-1:0]   s1_data,
  output logic                m_request_enable,
  output logic                m_mode,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_response_enable,
  input  logic [DATA_W-1:0]   m_data,
  output logic                busy
);

  memreq_t    req_in [2];
  memreq_t    slot   [2];
  logic [1:0] req_en;
  logic [1:0] pend;
  logic [1:0] clear;
  logic       grant;

  arb_state_t        state_reg;
  logic              owner_reg;
  logic              last_grant_reg;
  logic              m_req_reg;
  memreq_t           m_reg;
  logic [1:0]        s_resp_reg;
  logic [DATA_W-1:0] s_data_reg [2];

  assign req_in[0] = '{mode: s0_mode, addr: s0_addr, wdata: s0_wdata, wstrb: s0_wstrb};
  assign req_in[1] = '{mode: s1_mode, addr: s1_addr, wdata: s1_wdata, wstrb: s1_wstrb};
  assign req_en    = {s1_request_enable, s0_request_enable};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      mem_bus_arbiter_req_slot u_slot (
        .clk            (clk),
        .rstn           (rstn),
        .request_enable (req_en[gi]),
        .req            (req_in[gi]),
        .clear          (clear[gi]),
        .pend           (pend[gi]),
        .slot           (slot[gi])
      );
      // The owner's slot frees in the same edge its response is routed.
      assign clear[gi] = (state_reg == ARB_WAIT) && m_response_enable && (owner_reg == gi[0]);
    end
  endgenerate

  assign grant = pick_port(pend[0], pend[1], last_grant_reg);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg      <= ARB_IDLE;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      m_req_reg      <= 1'b0;
      m_reg          <= '0;
      s_resp_reg     <= 2'b00;
      s_data_reg[0]  <= '0;
      s_data_reg[1]  <= '0;
    end else begin
      m_req_reg  <= 1'b0;
      s_resp_reg <= 2'b00;
      case (state_reg)
        ARB_IDLE: begin
          // A response arriving here is stale and deliberately ignored.
          if (|pend) begin
            m_reg          <= slot[grant];
            m_req_reg      <= 1'b1;
            owner_reg      <= grant;
            last_grant_reg <= grant;
            state_reg      <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (m_response_enable) begin
            s_resp_reg[owner_reg] <= 1'b1;
            s_data_reg[owner_reg] <= m_data;
            state_reg             <= ARB_IDLE;
          end
        end
        default: state_reg <= ARB_IDLE;
      endcase
    end
  end

  assign m_request_enable   = m_req_reg;
  assign m_mode             = m_reg.mode;
  assign m_addr             = m_reg.addr;
  assign m_wdata            = m_reg.wdata;
  assign m_wstrb            = m_reg.wstrb;
  assign s0_response_enable = s_resp_reg[0];
  assign s1_response_enable = s_resp_reg[1];
  assign s0_data            = s_data_reg[0];
  assign s1_data            = s_data_reg[1];
  assign busy               = (state_reg == ARB_WAIT);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized checks of mem_bus_arbiter against a transaction-level
// reference model that is stepped once per clock edge.
module tb_mem_bus_arbiter;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  logic        clk = 1'b0;
  logic        rstn;
  logic        s0_request_enable, s0_mode;
  logic [31:0] s0_addr, s0_wdata;
  logic [3:0]  s0_wstrb;
  logic        s0_response_enable;
  logic [31:0] s0_data;
  logic        s1_request_enable, s1_mode;
  logic [31:0] s1_addr, s1_wdata;
  logic [3:0]  s1_wstrb;
  logic        s1_response_enable;
  logic [31:0] s1_data;
  logic        m_request_enable, m_mode;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_response_enable;
  logic [31:0] m_data;
  logic        busy;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rstn(rstn),
    .s0_request_enable(s0_request_enable), .s0_mode(s0_mode), .s0_addr(s0_addr),
    .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
    .s0_response_enable(s0_response_enable), .s0_data(s0_data),
    .s1_request_enable(s1_request_enable), .s1_mode(s1_mode), .s1_addr(s1_addr),
    .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb),
    .s1_response_enable(s1_response_enable), .s1_data(s1_data),
    .m_request_enable(m_request_enable), .m_mode(m_mode), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_response_enable(m_response_enable), .m_data(m_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: pending requests per port, last winner, bus ownership.
  logic        md_pend [2];
  logic        md_mode [2];
  logic [31:0] md_addr [2];
  logic [31:0] md_wdata[2];
  logic [3:0]  md_wstrb[2];
  logic        md_last, md_busy;
  int          md_owner;
  logic        e_mreq, e_mode;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_wstrb;
  logic [1:0]  e_resp;
  logic [31:0] e_data[2];

  // Bench-side memory and requester behaviour.
  logic        mem_auto = 1'b1;
  int          mem_lat = 2;
  logic        mem_rand_lat = 1'b0;
  int          mem_cnt = 0;
  logic        mem_fix_en = 1'b0;
  logic [31:0] mem_fix = 32'h0;
  logic        rr_auto = 1'b0;
  int          n_resp0 = 0, n_resp1 = 0;
  logic [31:0] grant_log[$];
  int          grant_cyc[$];
  logic        saw_300 = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic cap0, cap1;
    int   g;
    if (!rstn) begin
      for (int p = 0; p < 2; p++) begin
        md_pend[p] = 0; md_mode[p] = 0; md_addr[p] = 0; md_wdata[p] = 0; md_wstrb[p] = 0;
        e_data[p] = 0;
      end
      md_last = 1; md_busy = 0; md_owner = 0;
      e_mreq = 0; e_mode = 0; e_addr = 0; e_wdata = 0; e_wstrb = 0; e_resp = 0;
      return;
    end
    cap0 = s0_request_enable && !md_pend[0];
    cap1 = s1_request_enable && !md_pend[1];
    e_mreq = 0;
    e_resp = 0;
    if (!md_busy && (md_pend[0] || md_pend[1])) begin
      if (md_pend[0] && md_pend[1]) g = md_last ? 0 : 1;
      else                          g = md_pend[1] ? 1 : 0;
      e_mreq = 1; e_mode = md_mode[g]; e_addr = md_addr[g];
      e_wdata = md_wdata[g]; e_wstrb = md_wstrb[g];
      md_busy = 1; md_owner = g; md_last = g[0];
    end else if (md_busy && m_response_enable) begin
      e_resp[md_owner] = 1;
      e_data[md_owner] = m_data;
      md_pend[md_owner] = 0;
      md_busy = 0;
    end
    if (cap0) begin
      md_pend[0] = 1; md_mode[0] = s0_mode; md_addr[0] = s0_addr;
      md_wdata[0] = s0_wdata; md_wstrb[0] = s0_wstrb;
    end
    if (cap1) begin
      md_pend[1] = 1; md_mode[1] = s1_mode; md_addr[1] = s1_addr;
      md_wdata[1] = s1_wdata; md_wstrb[1] = s1_wstrb;
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    s0_request_enable = 0;
    s1_request_enable = 0;
    m_response_enable = 0;
    chk("m_request_enable", m_request_enable, e_mreq);
    chk("m_mode", m_mode, e_mode);
    chk("m_addr", m_addr, e_addr);
    chk("m_wdata", m_wdata, e_wdata);
    chk("m_wstrb", m_wstrb, e_wstrb);
    chk("s0_response_enable", s0_response_enable, e_resp[0]);
    chk("s1_response_enable", s1_response_enable, e_resp[1]);
    chk("s0_data", s0_data, e_data[0]);
    chk("s1_data", s1_data, e_data[1]);
    chk("busy", busy, md_busy);
    if (m_addr == 32'h300) saw_300 = 1;
    if (s0_response_enable) n_resp0++;
    if (s1_response_enable) n_resp1++;
    if (!rstn) mem_cnt = 0;
    if (m_request_enable) begin
      grant_log.push_back(m_addr);
      grant_cyc.push_back(cyc);
      if (mem_auto) mem_cnt = mem_rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
    end
    m_data = $urandom;
    if (mem_auto && mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        m_response_enable = 1;
        m_data = mem_fix_en ? mem_fix : $urandom;
      end
    end
    if (rr_auto && s0_response_enable && n_resp0 < 10) begin
      s0_request_enable = 1; s0_mode = RD; s0_addr = 32'h1000 + n_resp0 * 4;
    end
    if (rr_auto && s1_response_enable && n_resp1 < 10) begin
      s1_request_enable = 1; s1_mode = WR; s1_addr = 32'h2000 + n_resp1 * 4;
    end
    $display("cyc=%0d mreq=%0b maddr=%0h resp=%0b%0b busy=%0b", cyc, m_request_enable,
             m_addr, s1_response_enable, s0_response_enable, busy);
  endtask

  task automatic clear_logs();
    n_resp0 = 0; n_resp1 = 0;
    grant_log.delete();
    grant_cyc.delete();
  endtask

  task automatic do_reset();
    rstn = 0;
    repeat (3) cycle();
    rstn = 1;
    clear_logs();
  endtask

  task automatic run_until_resp(input int want, input string tag);
    int i;
    for (i = 0; i < 200 && (n_resp0 + n_resp1) < want; i++) cycle();
    chk({tag, "_responses_within_budget"}, n_resp0 + n_resp1, want);
  endtask

  initial begin
    rstn = 0;
    s0_request_enable = 0; s0_mode = 0; s0_addr = 0; s0_wdata = 0; s0_wstrb = 0;
    s1_request_enable = 0; s1_mode = 0; s1_addr = 0; s1_wdata = 0; s1_wstrb = 0;
    m_response_enable = 0; m_data = 0;

    // Reset state is checked by every cycle while rstn is low.
    do_reset();

    // Single read on port 0.
    mem_fix_en = 1; mem_fix = 32'hDEADBEEF; mem_lat = 2;
    s0_request_enable = 1; s0_mode = RD; s0_addr = 32'h100;
    cycle();
    run_until_resp(1, "t1");
    repeat (3) cycle();
    chk("t1_s0_count", n_resp0, 1);
    chk("t1_s1_count", n_resp1, 0);
    chk("t1_grants", grant_log.size(), 1);
    chk("t1_addr", grant_log[0], 32'h100);
    chk("t1_s0_data", s0_data, 32'hDEADBEEF);
    clear_logs();

    // Single store on port 1.
    mem_fix = 32'h12345678;
    s1_request_enable = 1; s1_mode = WR; s1_addr = 32'h204; s1_wdata = 32'h0000AB00; s1_wstrb = 4'b0010;
    cycle();
    run_until_resp(1, "t2");
    repeat (3) cycle();
    chk("t2_s1_count", n_resp1, 1);
    chk("t2_s0_count", n_resp0, 0);
    chk("t2_grants", grant_log.size(), 1);
    clear_logs();
    mem_fix_en = 0;

    // Simultaneous requests after reset: port 0 first, one idle cycle between issues.
    do_reset();
    s0_request_enable = 1; s0_mode = RD; s0_addr = 32'h1100;
    s1_request_enable = 1; s1_mode = WR; s1_addr = 32'h2200; s1_wdata = 32'hCAFE0000; s1_wstrb = 4'b1100;
    cycle();
    run_until_resp(2, "t3");
    repeat (2) cycle();
    chk("t3_grants", grant_log.size(), 2);
    chk("t3_first", grant_log[0], 32'h1100);
    chk("t3_second", grant_log[1], 32'h2200);
    chk("t3_issue_gap", grant_cyc[1] - grant_cyc[0], mem_lat + 1);
    chk("t3_counts", {n_resp0[15:0], n_resp1[15:0]}, {16'd1, 16'd1});
    clear_logs();

    // Continuous contention for 10 rounds: strict alternation starting with port 0.
    do_reset();
    rr_auto = 1;
    s0_request_enable = 1; s0_mode = RD; s0_addr = 32'h1000;
    s1_request_enable = 1; s1_mode = WR; s1_addr = 32'h2000;
    cycle();
    run_until_resp(20, "t4");
    rr_auto = 0;
    repeat (3) cycle();
    chk("t4_s0_served", n_resp0, 10);
    chk("t4_s1_served", n_resp1, 10);
    chk("t4_grants", grant_log.size(), 20);
    for (int i = 0; i < 20 && i < grant_log.size(); i++) begin
      logic [31:0] a;
      a = grant_log[i];
      chk($sformatf("t4_order_%0d", i), a[13:12], (i % 2 == 0) ? 2'd1 : 2'd2);
    end
    clear_logs();

    // Re-request while pending is dropped.
    mem_lat = 3;
    saw_300 = 0;
    s0_request_enable = 1; s0_mode = RD; s0_addr = 32'h200;
    cycle();
    s0_request_enable = 1; s0_addr = 32'h300;
    cycle();
    run_until_resp(1, "t5");
    repeat (4) cycle();
    chk("t5_grants", grant_log.size(), 1);
    chk("t5_addr", grant_log[0], 32'h200);
    chk("t5_never_300", saw_300, 1'b0);
    clear_logs();
    mem_lat = 2;

    // Reset during WAIT, then a stale response afterwards.
    s1_request_enable = 1; s1_mode = RD; s1_addr = 32'h440;
    mem_auto = 0;
    cycle();
    cycle();
    chk("t6_in_wait", busy, 1'b1);
    rstn = 0;
    repeat (2) cycle();
    rstn = 1;
    clear_logs();
    cycle();
    m_response_enable = 1; m_data = 32'h5A5A5A5A;
    cycle();
    repeat (3) cycle();
    chk("t6_no_resp", n_resp0 + n_resp1, 0);
    chk("t6_no_issue", grant_log.size(), 0);
    chk("t6_busy", busy, 1'b0);
    mem_auto = 1;

    // Randomized traffic with random latency, fields and protocol violations.
    mem_rand_lat = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        s0_request_enable = 1; s0_mode = 1'($urandom); s0_addr = $urandom;
        s0_wdata = $urandom; s0_wstrb = 4'($urandom);
      end
      if ($urandom_range(0, 3) == 0) begin
        s1_request_enable = 1; s1_mode = 1'($urandom); s1_addr = $urandom;
        s1_wdata = $urandom; s1_wstrb = 4'($urandom);
      end
      cycle();
    end
    repeat (20) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-requester arbiter for the single core memory bus.
- Port 0 serves instruction fetch; port 1 serves the mem stage (loads, stores, atomic read/write).
- Each requester issues a one-cycle request pulse and waits for a one-cycle response pulse. The arbiter latches each request, issues one outstanding bus transaction at a time in round-robin order, and routes the response back to the owner.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- s0_request_enable  in  1  port 0 request pulse
- s0_mode  in  1  port 0 MEMREQ_READ/MEMREQ_WRITE
- s0_addr  in  ADDR_W  port 0 address
- s0_wdata  in  DATA_W  port 0 write data
- s0_wstrb  in  DATA_W/8  port 0 byte strobes
- s0_response_enable  out  1  port 0 response pulse
- s0_data  out  DATA_W  port 0 read data
- s1_* (same seven signals as s0_*)  port 1 (mem stage)
- m_request_enable  out  1  downstream request pulse
- m_mode  out  1  downstream mode
- m_addr  out  ADDR_W  downstream address
- m_wdata  out  DATA_W  downstream write data
- m_wstrb  out  DATA_W/8  downstream strobes
- m_response_enable  in  1  downstream response pulse
- m_data  in  DATA_W  downstream read data
- busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE; both pending flags=0; last_grant=1, so port 0 wins the first tie. All outputs are 0: m_request_enable, m_mode, m_addr, m_wdata, m_wstrb, sN_response_enable, sN_data, busy.
- Capture: on a posedge where sN_request_enable=1 and pendN=0, set pendN=1 and latch mode/addr/wdata/wstrb into the port N slot. A request while pendN=1 is a protocol violation; it is dropped and the slot is unchanged.
- States: IDLE, WAIT.
- IDLE, at least one pendN=1 (registered value):
  - Select the owner. If only one port is pending, that port wins. If both are pending, the port != last_grant wins.
  - Load m_* from the owner's slot and set m_request_enable=1.
  - Set owner and last_grant to the selected port; go to WAIT.
- WAIT:
  - m_request_enable=0 from the cycle after issue; m_addr/m_mode/m_wdata/m_wstrb hold.
  - On m_response_enable=1: sOWNER_data<=m_data, sOWNER_response_enable<=1 for exactly one cycle, pendOWNER<=0, go to IDLE.
- The non-owner's response_enable stays 0, and its data is unchanged.
- sN_response_enable is 0 in every cycle other than the routed response cycle.
- Latency: request pulse sampled at edge k, m_request_enable high after edge k+1, response routed one edge after m_response_enable.
- Minimum request-to-response is 3 edges plus the memory latency.
- After a response the arbiter returns to IDLE for one cycle, so back-to-back transactions have a one-cycle gap between m_request_enable pulses.
- Simultaneous events:
  - Request on port A in the same cycle as a response to port B: A is captured normally.
  - Both ports requesting in the same cycle: both are captured, then arbitrated round-robin.
- m_response_enable in IDLE is ignored; this includes a stale response after a reset mid-transaction.
- Reset in WAIT aborts the transaction; the requester is expected to be reset too.
- No starvation: with both ports continuously pending, grants strictly alternate.

Decomposition:
- Shared package def.sv:
  - MEMREQ_READ/MEMREQ_WRITE
  - memreq struct {mode, addr, wdata, wstrb}, used for the port slots and m_*
  - state localparams ARB_IDLE/ARB_WAIT
- Sub-module req_slot: one capture register plus pending flag, instantiated twice. Inputs: request pulse, fields, clear. Outputs: pend, memreq.

Test Plan:
- Single read on port 0 (addr 0x100): memory answers 0xDEADBEEF 2 cycles after m_request_enable. Expect m_addr=0x100 and m_mode=READ; s0_response_enable pulses once with s0_data=0xDEADBEEF; s1_response_enable stays 0.
- Single store on port 1 (addr 0x204, wdata 0x0000AB00, wstrb 0010): expect m_* equal to these values with mode=WRITE, one m_request_enable pulse, one s1_response_enable pulse.
- Both ports pulse in the same cycle after reset: expect port 0 granted first, then port 1, with a one-cycle gap between m_request_enable pulses and each response routed to the correct port.
- Both ports re-request immediately after every response, 10 rounds: expect grant order 0,1,0,1,… and each port served exactly 10 times.
- Port 0 pulses again while still pending with addr 0x300: expect a single transaction at the original address, with 0x300 never appearing on m_addr.
- Reset asserted in WAIT, then m_response_enable pulsed after release: expect no sN_response_enable and no m_request_enable, busy=0.
